// File: rtl/lfsr_sched_pkg.sv
// Shared types and helpers for the LFSR round-robin scheduler: state encoding,
// Galois feedback mask and the seed lock-up guard.
package lfsr_sched_pkg;

    localparam logic [31:0] TAP_MASK      = 32'hA300_0001;
    localparam logic [31:0] ZERO_SEED_SUB = 32'h0000_0001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        GRANT = 2'd2
    } state_e;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? TAP_MASK : 32'h0);
    endfunction

    // An all-zero Galois LFSR never leaves zero, so zero is replaced on load.
    function automatic logic [31:0] seed_guard(input logic [31:0] v);
        return (v == 32'h0) ? ZERO_SEED_SUB : v;
    endfunction

endpackage

// File: rtl/lfsr_rr_sched_if.sv
// Bus between the scheduler and its requesters. Handshake: a requester holds its req bit
// high until it sees its gnt bit for one cycle; rnd_word is valid while rnd_valid is high.
interface lfsr_rr_sched_if #(
    parameter int N_REQ = 4
);
    logic                     seed_load;
    logic [31:0]              seed_val;
    logic [N_REQ-1:0]         req;
    logic [N_REQ-1:0]         gnt;
    logic                     rnd_valid;
    logic [31:0]              rnd_word;
    logic                     busy;
    lfsr_sched_pkg::state_e   dbg_state;

    modport master (
        output seed_load, seed_val, req,
        input  gnt, rnd_valid, rnd_word, busy, dbg_state
    );

    modport slave (
        input  seed_load, seed_val, req,
        output gnt, rnd_valid, rnd_word, busy, dbg_state
    );
endinterface

// File: rtl/lfsr32_galois.sv
// 32-bit Galois LFSR register with seed load (priority) and step enable.
module lfsr32_galois
    import lfsr_sched_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_en,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [31:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= seed_guard(SEED);
        end else if (load) begin
            state <= seed_guard(load_val);
        end else if (step_en) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/lfsr_rr_sched.sv
// Round-robin scheduler serving decorrelated words from one shared 32-bit Galois LFSR.
// Build option LFSR_SCHED_FREERUN_EN: the LFSR also advances in IDLE and GRANT cycles.
module lfsr_rr_sched
    import lfsr_sched_pkg::*;
#(
    parameter int          N_REQ = 4,
    parameter int          STEPS = 32,
    parameter logic [31:0] SEED  = 32'h0000_0001
) (
    input  logic           clk,
    input  logic           rst_n,
    lfsr_rr_sched_if.slave bus
);

    localparam int               PTR_W    = $clog2(N_REQ);
    localparam logic [PTR_W-1:0] LAST     = PTR_W'(N_REQ - 1);
    localparam logic [7:0]       CNT_INIT = 8'(STEPS - 1);
`ifdef LFSR_SCHED_FREERUN_EN
    localparam logic             FREERUN  = 1'b1;
`else
    localparam logic             FREERUN  = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] winner_q, winner_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             rnd_valid_q, rnd_valid_d;
    logic [31:0]      rnd_word_q, rnd_word_d;
    logic             busy_q;
    logic             step_en;
    logic [31:0]      lfsr_q;

    // First set request at or after p, searching cyclically.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = p;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(p) + i) % N_REQ;
            if (!found && r[idx[PTR_W-1:0]]) begin
                pick  = idx[PTR_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    lfsr32_galois #(
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .step_en  (step_en),
        .load     (bus.seed_load),
        .load_val (bus.seed_val),
        .state    (lfsr_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        winner_d    = winner_q;
        gnt_d       = '0;
        rnd_valid_d = 1'b0;
        rnd_word_d  = rnd_word_q;
        step_en     = FREERUN;

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    winner_d = rr_pick(bus.req, ptr_q);
                    cnt_d    = CNT_INIT;
                    state_d  = STEP;
                end
            end
            STEP: begin
                step_en = 1'b1;
                if (cnt_q == 8'd0) begin
                    rnd_word_d        = lfsr_step(lfsr_q);
                    gnt_d[winner_q]   = 1'b1;
                    rnd_valid_d       = 1'b1;
                    state_d           = GRANT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            GRANT: begin
                ptr_d   = (winner_q == LAST) ? '0 : winner_q + PTR_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Seeding aborts any in-flight request; ptr stays so the same winner is re-picked.
        if (bus.seed_load) begin
            state_d     = IDLE;
            cnt_d       = '0;
            gnt_d       = '0;
            rnd_valid_d = 1'b0;
            rnd_word_d  = rnd_word_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            winner_q    <= '0;
            gnt_q       <= '0;
            rnd_valid_q <= 1'b0;
            rnd_word_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            winner_q    <= winner_d;
            gnt_q       <= gnt_d;
            rnd_valid_q <= rnd_valid_d;
            rnd_word_q  <= rnd_word_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rnd_valid = rnd_valid_q;
    assign bus.rnd_word  = rnd_word_q;
    assign bus.busy      = busy_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_lfsr_rr_sched.sv
// Bench for lfsr_rr_sched: two instances (STEPS=32 and STEPS=1) checked against vector
// tables, hand-written corner sequences and a polynomial-arithmetic reference model.
module tb_lfsr_rr_sched;
    import lfsr_sched_pkg::*;

    localparam int N       = 4;
    localparam int STEPS_A = 32;
    localparam int STEPS_B = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lfsr_rr_sched_if #(.N_REQ(N)) bus_a ();
    lfsr_rr_sched_if #(.N_REQ(N)) bus_b ();

    lfsr_rr_sched #(.N_REQ(N), .STEPS(STEPS_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    lfsr_rr_sched #(.N_REQ(N), .STEPS(STEPS_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    logic [N-1:0] drv_req       [2];
    logic         drv_seed_load [2];
    logic [31:0]  drv_seed_val  [2];
    logic [N-1:0] o_gnt   [2];
    logic         o_valid [2];
    logic [31:0]  o_word  [2];
    logic         o_busy  [2];
    state_e       o_state [2];

    assign bus_a.req       = drv_req[0];
    assign bus_a.seed_load = drv_seed_load[0];
    assign bus_a.seed_val  = drv_seed_val[0];
    assign bus_b.req       = drv_req[1];
    assign bus_b.seed_load = drv_seed_load[1];
    assign bus_b.seed_val  = drv_seed_val[1];
    assign o_gnt[0]   = bus_a.gnt;
    assign o_valid[0] = bus_a.rnd_valid;
    assign o_word[0]  = bus_a.rnd_word;
    assign o_busy[0]  = bus_a.busy;
    assign o_state[0] = bus_a.dbg_state;
    assign o_gnt[1]   = bus_b.gnt;
    assign o_valid[1] = bus_b.rnd_valid;
    assign o_word[1]  = bus_b.rnd_word;
    assign o_busy[1]  = bus_b.busy;
    assign o_state[1] = bus_b.dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    logic [31:0] m_lfsr [2];
    int          m_ptr  [2];

    function automatic int steps_of(input int d);
        return (d == 0) ? STEPS_A : STEPS_B;
    endfunction

    // Multiply by x in GF(2)[x] modulo x^32 + x^31 + x^29 + x^25 + x^24 + 1.
    function automatic logic [31:0] gf_mul_x(input logic [31:0] s);
        logic [32:0] wide;
        wide = {1'b0, s} * 33'd2;
        return wide[32] ? (wide[31:0] ^ 32'hA300_0001) : wide[31:0];
    endfunction

    task automatic model_grant(input int d, input logic [N-1:0] r,
                               output logic [N-1:0] g, output logic [31:0] w);
        int win;
        win = -1;
        for (int i = 0; i < N; i++) begin
            if (win < 0 && r[(m_ptr[d] + i) % N]) win = (m_ptr[d] + i) % N;
        end
        for (int i = 0; i < steps_of(d); i++) m_lfsr[d] = gf_mul_x(m_lfsr[d]);
        g        = '0;
        g[win]   = 1'b1;
        w        = m_lfsr[d];
        m_ptr[d] = (win + 1) % N;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_lfsr[d] = 32'h1;
            m_ptr[d]  = 0;
        end
    endtask

    // ---------------- drivers / checkers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int d, input string name, output int lat, output logic seen);
        int budget;
        budget = 2 * steps_of(d) + 10;
        lat  = 0;
        seen = 1'b0;
        while (lat < budget && !seen) begin
            tick();
            lat++;
            if (o_valid[d]) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: actual=no grant after %0d cycles required=grant", name, lat);
        end
    endtask

    task automatic seed_pulse(input int d, input logic [31:0] v);
        drv_seed_load[d] = 1'b1;
        drv_seed_val[d]  = v;
        tick();
        drv_seed_load[d] = 1'b0;
        m_lfsr[d] = (v == 32'h0) ? 32'h1 : v;
    endtask

    task automatic serve(input int d, input logic [N-1:0] r, input logic [N-1:0] exp_gnt,
                         input logic [31:0] exp_word, input string name);
        int   lat;
        logic seen;
        logic [31:0] w;
        drv_req[d] = r;
        wait_valid(d, name, lat, seen);
        if (seen) begin
            check({name, "_gnt"},  64'(o_gnt[d]), 64'(exp_gnt));
            check({name, "_word"}, 64'(o_word[d]), 64'(exp_word));
            check({name, "_lat"},  64'(lat), 64'(steps_of(d) + 1));
        end
        w = o_word[d];
        drv_req[d] = '0;
        tick();
        check({name, "_gnt_pulse"}, 64'({o_valid[d], o_gnt[d]}), 64'd0);
        check({name, "_word_held"}, 64'(o_word[d]), 64'(w));
    endtask

    typedef struct {
        logic [31:0]  seed;
        logic [N-1:0] req;
        logic [N-1:0] exp_gnt;
        logic [31:0]  exp_word;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] eg;
        logic [31:0]  ew;
        logic [31:0]  words [$];
        int           lat;
        logic         seen;
        logic         spurious;

        // STEPS=1 vectors; ptr carries over between rows (0 -> 3 -> 2 -> 0 -> 2 -> 1).
        tbl[0] = '{32'h8000_0000, 4'b0100, 4'b0100, 32'hA300_0001};
        tbl[1] = '{32'h0000_0000, 4'b0010, 4'b0010, 32'h0000_0002};
        tbl[2] = '{32'h0000_0001, 4'b1001, 4'b1000, 32'h0000_0002};
        tbl[3] = '{32'hFFFF_FFFF, 4'b0110, 4'b0010, 32'h5CFF_FFFF};
        tbl[4] = '{32'h4000_0000, 4'b0011, 4'b0001, 32'h8000_0000};
        tbl[5] = '{32'h1234_5678, 4'b1111, 4'b0010, 32'h2468_ACF0};

        for (int d = 0; d < 2; d++) begin
            drv_req[d]       = '0;
            drv_seed_load[d] = 1'b0;
            drv_seed_val[d]  = '0;
        end
        model_reset();

        // Reset values
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            check("reset_gnt",   64'(o_gnt[d]), 64'd0);
            check("reset_valid", 64'(o_valid[d]), 64'd0);
            check("reset_word",  64'(o_word[d]), 64'd0);
            check("reset_busy",  64'(o_busy[d]), 64'd0);
            check("reset_state", 64'(o_state[d]), 64'(IDLE));
        end
        rst_n = 1'b1;
        tick();

        // Defaults: seed 1, requester 0, 32 steps
        model_grant(0, 4'b0001, eg, ew);
        serve(0, 4'b0001, 4'b0001, 32'hA300_0001, "default_req0");

        // Table on the STEPS=1 instance
        for (int i = 0; i < 6; i++) begin
            seed_pulse(1, tbl[i].seed);
            model_grant(1, tbl[i].req, eg, ew);
            serve(1, tbl[i].req, tbl[i].exp_gnt, tbl[i].exp_word, $sformatf("tbl%0d", i));
        end

        // Reset mid-STEP aborts asynchronously
        drv_req[0] = 4'b0010;
        for (int i = 0; i < 10; i++) tick();
        check("midstep_busy_before", 64'(o_busy[0]), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'({o_gnt[0], o_valid[0], o_busy[0]}), 64'd0);
        check("async_reset_word", 64'(o_word[0]), 64'd0);
        check("async_reset_state", 64'(o_state[0]), 64'(IDLE));
        drv_req[0] = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (o_valid[0] || o_valid[1] || (o_gnt[0] != 0) || (o_gnt[1] != 0)) spurious = 1'b1;
        end
        check("no_spurious_gnt_after_reset", 64'(spurious), 64'd0);

        // All requesters held: rotation 0,1,2,3,0 spaced STEPS+2 apart, from LFSR=SEED
        drv_req[0] = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_valid(0, "rr_hold", lat, seen);
            model_grant(0, 4'b1111, eg, ew);
            if (seen) begin
                check($sformatf("rr_hold%0d_gnt", g),  64'(o_gnt[0]), 64'(eg));
                check($sformatf("rr_hold%0d_word", g), 64'(o_word[0]), 64'(ew));
                check($sformatf("rr_hold%0d_lat", g), 64'(lat),
                      64'((g == 0) ? STEPS_A + 1 : STEPS_A + 2));
                words.push_back(o_word[0]);
            end
        end
        check("rr_hold_first_word", 64'((words.size() > 0) ? words[0] : 32'h0), 64'h0000_0000_A300_0001);
        begin
            int dup;
            dup = 0;
            for (int i = 0; i < words.size(); i++)
                for (int j = i + 1; j < words.size(); j++)
                    if (words[i] == words[j]) dup++;
            check("rr_hold_words_distinct", 64'(dup), 64'd0);
        end
        drv_req[0] = '0;
        tick();

        // seed_load during STEP aborts; requester 1 (ptr) re-wins afterwards
        drv_req[0] = 4'b0010;
        spurious = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_valid[0]) spurious = 1'b1;
        end
        check("abort_busy_before", 64'(o_busy[0]), 64'd1);
        drv_seed_load[0] = 1'b1;
        drv_seed_val[0]  = 32'h0000_0001;
        tick();
        drv_seed_load[0] = 1'b0;
        m_lfsr[0] = 32'h1;
        if (o_valid[0]) spurious = 1'b1;
        check("abort_busy_dropped", 64'(o_busy[0]), 64'd0);
        check("abort_no_gnt", 64'(spurious), 64'd0);
        model_grant(0, 4'b0010, eg, ew);
        wait_valid(0, "abort_regrant", lat, seen);
        if (seen) begin
            check("abort_regrant_gnt",  64'(o_gnt[0]), 64'h2);
            check("abort_regrant_word", 64'(o_word[0]), 64'(ew));
            check("abort_regrant_lat",  64'(lat), 64'(STEPS_A + 1));
        end
        drv_req[0] = '0;
        tick();

        // Randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            int d;
            logic [N-1:0] r;
            d = (it < 16) ? 0 : 1;
            if ($urandom_range(0, 3) == 0)
                seed_pulse(d, ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom);
            r = N'($urandom_range(1, (1 << N) - 1));
            model_grant(d, r, eg, ew);
            serve(d, r, eg, ew, $sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
